// File: rtl/riscv_signature_pkg.sv
// Shared types for the signature-write protocol: word type codes, core status and
// test result encodings, plus the decoder FSM state.
package riscv_signature_pkg;

   localparam int SIG_TYPE_W = 8;

   typedef enum logic [SIG_TYPE_W-1:0] {
      CORE_STATUS = 8'h00,
      TEST_RESULT = 8'h01,
      WRITE_GPR   = 8'h02,
      WRITE_CSR   = 8'h03
   } signature_type_t;

   typedef enum logic [4:0] {
      INITIALIZED             = 5'd0,
      IN_DEBUG_MODE           = 5'd1,
      IN_MACHINE_MODE         = 5'd2,
      IN_HYPERVISOR_MODE      = 5'd3,
      IN_SUPERVISOR_MODE      = 5'd4,
      IN_USER_MODE            = 5'd5,
      HANDLING_IRQ            = 5'd6,
      FINISHED_IRQ            = 5'd7,
      HANDLING_EXCEPTION      = 5'd8,
      INSTR_FAULT_EXCEPTION   = 5'd9,
      ILLEGAL_INSTR_EXCEPTION = 5'd10,
      LOAD_FAULT_EXCEPTION    = 5'd11,
      STORE_FAULT_EXCEPTION   = 5'd12,
      EBREAK_EXCEPTION        = 5'd13
   } core_status_t;

   typedef enum logic {
      TEST_PASS = 1'b0,
      TEST_FAIL = 1'b1
   } test_result_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GPR_DUMP = 2'd1,
      CSR_DATA = 2'd2
   } dec_state_t;

   localparam core_status_t CORE_STATUS_MAX = EBREAK_EXCEPTION;

endpackage

// File: rtl/riscv_signature_decoder_if.sv
// Snooped data-side write bus plus the decoded event outputs of the signature decoder.
interface riscv_signature_decoder_if #(
   parameter int XLEN = 32
);
   logic            wr_valid_i;
   logic [31:0]     wr_addr_i;
   logic [XLEN-1:0] wr_data_i;
   logic            status_valid_o;
   logic [4:0]      core_status_o;
   logic            test_done_o;
   logic            test_pass_o;
   logic            gpr_valid_o;
   logic [4:0]      gpr_idx_o;
   logic [XLEN-1:0] gpr_data_o;
   logic            csr_valid_o;
   logic [11:0]     csr_addr_o;
   logic [XLEN-1:0] csr_data_o;
   logic            proto_err_o;
   logic            busy_o;

   modport master (
      output wr_valid_i, wr_addr_i, wr_data_i,
      input  status_valid_o, core_status_o, test_done_o, test_pass_o,
             gpr_valid_o, gpr_idx_o, gpr_data_o, csr_valid_o, csr_addr_o,
             csr_data_o, proto_err_o, busy_o
   );

   modport slave (
      input  wr_valid_i, wr_addr_i, wr_data_i,
      output status_valid_o, core_status_o, test_done_o, test_pass_o,
             gpr_valid_o, gpr_idx_o, gpr_data_o, csr_valid_o, csr_addr_o,
             csr_data_o, proto_err_o, busy_o
   );
endinterface

// File: rtl/riscv_signature_decoder.sv
// Filters stores to the signature address and turns them into registered typed events;
// GPR dumps and CSR writes span several words and are reassembled by the FSM below.
//
// state    | meaning
// IDLE     | next hit is a type word
// GPR_DUMP | hits are GPR values x0..x(NUM_GPR-1), counter holds next index
// CSR_DATA | next hit is the value for the latched CSR address
module riscv_signature_decoder
   import riscv_signature_pkg::*;
#(
   parameter logic [31:0] SIG_ADDR = 32'h8FFF_FFF8,
   parameter int          XLEN     = 32,
   parameter int          NUM_GPR  = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   riscv_signature_decoder_if.slave    bus
);

   localparam int CNT_W = $clog2(NUM_GPR);

   dec_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic            status_valid_d, test_done_d, test_pass_d;
   logic            gpr_valid_d, csr_valid_d, proto_err_d;
   logic [4:0]      core_status_d, gpr_idx_d;
   logic [11:0]     csr_addr_d;
   logic [XLEN-1:0] gpr_data_d, csr_data_d;

   logic                  hit;
   logic [SIG_TYPE_W-1:0] type_code;

   assign hit       = bus.wr_valid_i && (bus.wr_addr_i == SIG_ADDR);
   assign type_code = bus.wr_data_i[SIG_TYPE_W-1:0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      status_valid_d = 1'b0;
      gpr_valid_d    = 1'b0;
      csr_valid_d    = 1'b0;
      proto_err_d    = 1'b0;
      core_status_d  = bus.core_status_o;
      test_done_d    = bus.test_done_o;
      test_pass_d    = bus.test_pass_o;
      gpr_idx_d      = bus.gpr_idx_o;
      gpr_data_d     = bus.gpr_data_o;
      csr_addr_d     = bus.csr_addr_o;
      csr_data_d     = bus.csr_data_o;

      if (hit) begin
         unique case (state_q)
            IDLE: begin
               case (type_code)
                  CORE_STATUS: begin
                     if (bus.wr_data_i[12:8] <= CORE_STATUS_MAX) begin
                        core_status_d  = bus.wr_data_i[12:8];
                        status_valid_d = 1'b1;
                     end else begin
                        proto_err_d = 1'b1;
                     end
                  end
                  TEST_RESULT: begin
                     // first result wins; later ones are flagged and dropped
                     if (bus.test_done_o) begin
                        proto_err_d = 1'b1;
                     end else begin
                        test_done_d = 1'b1;
                        test_pass_d = (test_result_t'(bus.wr_data_i[8]) == TEST_PASS);
                     end
                  end
                  WRITE_GPR: begin
                     cnt_d   = '0;
                     state_d = GPR_DUMP;
                  end
                  WRITE_CSR: begin
                     csr_addr_d = bus.wr_data_i[19:8];
                     state_d    = CSR_DATA;
                  end
                  default: proto_err_d = 1'b1;
               endcase
            end
            GPR_DUMP: begin
               gpr_data_d  = bus.wr_data_i;
               gpr_idx_d   = 5'(cnt_q);
               gpr_valid_d = 1'b1;
               if (cnt_q == CNT_W'(NUM_GPR - 1)) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            CSR_DATA: begin
               csr_data_d  = bus.wr_data_i;
               csr_valid_d = 1'b1;
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bus.status_valid_o <= 1'b0;
         bus.core_status_o  <= INITIALIZED;
         bus.test_done_o    <= 1'b0;
         bus.test_pass_o    <= 1'b0;
         bus.gpr_valid_o    <= 1'b0;
         bus.gpr_idx_o      <= '0;
         bus.gpr_data_o     <= '0;
         bus.csr_valid_o    <= 1'b0;
         bus.csr_addr_o     <= '0;
         bus.csr_data_o     <= '0;
         bus.proto_err_o    <= 1'b0;
         bus.busy_o         <= 1'b0;
      end else begin
         bus.status_valid_o <= status_valid_d;
         bus.core_status_o  <= core_status_d;
         bus.test_done_o    <= test_done_d;
         bus.test_pass_o    <= test_pass_d;
         bus.gpr_valid_o    <= gpr_valid_d;
         bus.gpr_idx_o      <= gpr_idx_d;
         bus.gpr_data_o     <= gpr_data_d;
         bus.csr_valid_o    <= csr_valid_d;
         bus.csr_addr_o     <= csr_addr_d;
         bus.csr_data_o     <= csr_data_d;
         bus.proto_err_o    <= proto_err_d;
         bus.busy_o         <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_riscv_signature_decoder.sv
// Scoreboard bench for riscv_signature_decoder: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the decoder emits a pulse.
module tb_riscv_signature_decoder;
   import riscv_signature_pkg::*;

   localparam logic [31:0] SA = 32'h8FFF_FFF8;

   typedef enum int {EV_STATUS, EV_GPR, EV_CSR, EV_ERR} ev_kind_e;
   typedef struct {
      ev_kind_e    kind;
      int          cyc;
      logic [31:0] a;
      logic [31:0] d;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   ev_t  q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   riscv_signature_decoder_if #(.XLEN(32)) bus ();

   riscv_signature_decoder #(
      .SIG_ADDR (SA),
      .XLEN     (32),
      .NUM_GPR  (32)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wr_v(input logic v, input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.wr_valid_i = v;
      bus.wr_addr_i  = addr;
      bus.wr_data_i  = data;
   endtask

   task automatic wr(input logic [31:0] data);
      wr_v(1'b1, SA, data);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.wr_valid_i = 1'b0;
      end
   endtask

   // call right after the write that should produce the event
   task automatic exp_ev(input ev_kind_e k, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      e.kind = k;
      e.cyc  = cyc + 1;
      e.a    = a;
      e.d    = d;
      q.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_status_valid"}, 32'(bus.status_valid_o), 0);
      check({tag, "_core_status"},  32'(bus.core_status_o), 32'(INITIALIZED));
      check({tag, "_test_done"},    32'(bus.test_done_o), 0);
      check({tag, "_test_pass"},    32'(bus.test_pass_o), 0);
      check({tag, "_gpr_valid"},    32'(bus.gpr_valid_o), 0);
      check({tag, "_gpr_idx"},      32'(bus.gpr_idx_o), 0);
      check({tag, "_gpr_data"},     bus.gpr_data_o, 0);
      check({tag, "_csr_valid"},    32'(bus.csr_valid_o), 0);
      check({tag, "_csr_addr"},     32'(bus.csr_addr_o), 0);
      check({tag, "_csr_data"},     bus.csr_data_o, 0);
      check({tag, "_proto_err"},    32'(bus.proto_err_o), 0);
      check({tag, "_busy"},         32'(bus.busy_o), 0);
   endtask

   // monitor
   ev_t mon_e;
   int  mon_np;
   int  mon_kind;
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         mon_np = int'(bus.status_valid_o) + int'(bus.gpr_valid_o) +
                  int'(bus.csr_valid_o) + int'(bus.proto_err_o);
         if (mon_np > 1) begin
            n_checks++;
            n_errors++;
            $display("FAIL multi_pulse: got %0d pulses expected 1 (cycle %0d)", mon_np, cyc);
         end else if (mon_np == 1) begin
            mon_kind = bus.status_valid_o ? EV_STATUS :
                       bus.gpr_valid_o    ? EV_GPR    :
                       bus.csr_valid_o    ? EV_CSR    : EV_ERR;
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)",
                        mon_kind, cyc);
            end else begin
               mon_e = q.pop_front();
               check("ev_kind", 32'(mon_kind), 32'(mon_e.kind));
               check("ev_latency", 32'(cyc), 32'(mon_e.cyc));
               case (mon_e.kind)
                  EV_STATUS: check("core_status", 32'(bus.core_status_o), mon_e.a);
                  EV_GPR: begin
                     check("gpr_idx", 32'(bus.gpr_idx_o), mon_e.a);
                     check("gpr_data", bus.gpr_data_o, mon_e.d);
                  end
                  EV_CSR: begin
                     check("csr_addr", 32'(bus.csr_addr_o), mon_e.a);
                     check("csr_data", bus.csr_data_o, mon_e.d);
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   initial begin
      rst            = 1'b1;
      bus.wr_valid_i = 1'b0;
      bus.wr_addr_i  = '0;
      bus.wr_data_i  = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // core status: valid, out of range, and the top legal code
      wr(32'h0000_0200);  exp_ev(EV_STATUS, 32'(IN_MACHINE_MODE), 0);
      wr(32'h0000_1F00);  exp_ev(EV_ERR, 0, 0);
      idle(2);
      check("status_hold", 32'(bus.core_status_o), 32'(IN_MACHINE_MODE));
      wr(32'h0000_0D00);  exp_ev(EV_STATUS, 32'(EBREAK_EXCEPTION), 0);
      wr(32'h0000_0E00);  exp_ev(EV_ERR, 0, 0);
      wr(32'h0000_0055);  exp_ev(EV_ERR, 0, 0);
      idle(2);
      check("status_after_err", 32'(bus.core_status_o), 32'(EBREAK_EXCEPTION));

      // full GPR dump, back to back
      wr(32'h0000_0002);
      for (int i = 0; i < 32; i++) begin
         wr(32'h100 + i);  exp_ev(EV_GPR, i, 32'h100 + i);
         if (i == 0) check("busy_in_dump", 32'(bus.busy_o), 1);
      end
      idle(1);
      check("busy_after_dump", 32'(bus.busy_o), 0);
      wr(32'h0000_0001);
      idle(1);
      check("done_after_dump", 32'(bus.test_done_o), 1);
      check("pass_after_dump", 32'(bus.test_pass_o), 1);
      wr(32'h0000_0101);  exp_ev(EV_ERR, 0, 0);
      idle(1);
      check("first_result_wins", 32'(bus.test_pass_o), 1);

      // CSR pair with ignored traffic in between
      wr(32'h0003_0003);
      wr_v(1'b1, SA + 32'd4, 32'hDEAD_0002);
      wr_v(1'b0, SA, 32'h0000_0002);
      idle(1);
      check("busy_in_csr", 32'(bus.busy_o), 1);
      wr(32'h0000_1800);  exp_ev(EV_CSR, 32'h300, 32'h1800);
      // payload that looks like a type code
      wr(32'h0000_0003);
      wr(32'h0000_0002);  exp_ev(EV_CSR, 32'h000, 32'h0000_0002);
      idle(2);
      check("busy_after_csr", 32'(bus.busy_o), 0);

      // reset in the middle of a dump
      wr(32'h0000_0002);
      for (int i = 0; i < 10; i++) begin
         wr(32'hA000 + i);  exp_ev(EV_GPR, i, 32'hA000 + i);
      end
      idle(1);
      #1 rst = 1'b1;
      #1 check_reset_outputs("mid_reset");
      check("queue_at_reset", 32'(q.size()), 0);
      @(negedge clk);
      rst = 1'b0;
      wr(32'h0000_0002);
      for (int i = 0; i < 32; i++) begin
         wr(32'hB000 + i);  exp_ev(EV_GPR, i, 32'hB000 + i);
      end

      // failing result, then a pass that must be rejected
      wr(32'h0000_0101);
      idle(1);
      check("done_fail", 32'(bus.test_done_o), 1);
      check("pass_fail", 32'(bus.test_pass_o), 0);
      wr(32'h0000_0001);  exp_ev(EV_ERR, 0, 0);
      idle(2);
      check("pass_stays_0", 32'(bus.test_pass_o), 0);

      idle(3);
      check("queue_empty", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
